vr_fifo: RTL and testbench
==========================

VR_FIFO -- requirements
Module: vr_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, number of storage entries; legal values are powers of two, 2 to 256.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit, upstream producer offers in_data.
REQ-006 SHALL have port in_data, input, WIDTH bits, upstream data word.
REQ-007 SHALL have port in_rdy, output, 1 bit, block can accept a word this cycle.
REQ-008 SHALL have port out_valid, output, 1 bit, out_data holds a valid word.
REQ-009 SHALL have port out_data, output, WIDTH bits, head-of-queue word.
REQ-010 SHALL have port out_rdy, input, 1 bit, downstream consumer accepts out_data.
REQ-011 SHALL have port count, output, $clog2(DEPTH+1) bits, current occupancy.
REQ-012 SHALL group ports in_valid/in_data/in_rdy as a consumer-side valid/ready port and out_valid/out_data/out_rdy as a producer-side valid/ready port, so each group binds directly to the team's valid/ready interface.

Function
REQ-013 SHALL count a push in any cycle where in_valid and in_rdy are both 1 at the clock edge.
REQ-014 SHALL count a pop in any cycle where out_valid and out_rdy are both 1 at the clock edge.
REQ-015 SHALL drive in_rdy = (count != DEPTH), decoded from registered state only; no combinational path from out_rdy or in_valid to in_rdy.
REQ-016 SHALL drive out_valid = (count != 0), decoded from registered state only; no combinational path from in_valid to out_valid.
REQ-017 SHALL drive out_data from the entry at the read pointer whenever out_valid=1 (first-word fall-through); its value is don't-care when out_valid=0.
REQ-018 SHALL have a latency of 1 cycle: a word pushed at edge N is visible on out_data with out_valid=1 after edge N when the queue was empty.
REQ-019 SHALL deliver words in strict push order, with no loss or duplication.
REQ-020 SHALL write in_data at the write pointer on a push, then increment the write pointer modulo DEPTH.
REQ-021 SHALL increment the read pointer modulo DEPTH on a pop; both pointers wrap from DEPTH-1 to 0.
REQ-022 SHALL update count as follows: push only, +1; pop only, -1; push and pop together, unchanged.
REQ-023 SHALL, when full (count=DEPTH), ignore in_valid because in_rdy=0; a pop in that cycle leaves count=DEPTH-1, and in_rdy returns to 1 in the next cycle.
REQ-024 SHALL, when empty (count=0), ignore out_rdy because out_valid=0; a push in that cycle leaves count=1.
REQ-025 SHALL keep out_data stable while out_valid=1 and out_rdy=0.
REQ-026 SHALL sustain one push and one pop per cycle when 0 < count < DEPTH.
REQ-027 SHALL require the upstream producer to hold in_valid and in_data stable until accepted; the block does not check this.

Reset
REQ-028 SHALL, on rst=1 at a clock edge, set read pointer=0, write pointer=0, count=0, out_valid=0, in_rdy=1.
REQ-029 SHALL have rst take priority over any push or pop in the same cycle; words held at reset are discarded.
REQ-030 SHALL leave storage contents unreset; they are unobservable because out_valid=0.
REQ-031 SHALL treat a reset mid-stream as a flush: after rst deasserts, the first word pushed is the first word popped.

Verification
REQ-032 SHALL be verified by this scenario: DEPTH=4, out_rdy=0, push 0x0001..0x0004 -> in_rdy=0 after the 4th push, count=4, out_data=0x0001; a 5th word 0x0005 held on in_valid is not accepted.
REQ-033 SHALL be verified by this scenario: from full, set out_rdy=1 for 4 cycles with in_valid=0 -> out_data 0x0001,0x0002,0x0003,0x0004 in order, then out_valid=0 and count=0.
REQ-034 SHALL be verified by this scenario: count=2, in_valid=1 and out_rdy=1 for 10 cycles -> count stays 2 and all pointers wrap at least twice with order preserved.
REQ-035 SHALL be verified by this scenario: full, with in_valid=1 (data 0x0005) and out_rdy=1 in the same cycle -> 0x0001 popped, 0x0005 not accepted, count=3, in_rdy=1 next cycle, 0x0005 accepted after that.
REQ-036 SHALL be verified by this scenario: count=3, rst=1 for one cycle while in_valid=1 and out_rdy=1 -> count=0, out_valid=0, in_rdy=1; next push 0x00AA emerges first.
REQ-037 SHALL be verified by this scenario: random in_valid/out_rdy with 50% density over 10000 cycles against a reference queue model -> zero data mismatches, and in_rdy/out_valid always consistent with count.

Source files
------------

// File: rtl/vr_fifo_if.sv
// Valid/ready channel: the master drives valid+data, the slave answers with rdy.
// A word transfers on any rising edge where valid and rdy are both high.
interface vr_if #(
    parameter int WIDTH = 16
);
    logic             valid;
    logic [WIDTH-1:0] data;
    logic             rdy;

    modport master (output valid, output data, input  rdy);
    modport slave  (input  valid, input  data, output rdy);
endinterface

// File: rtl/vr_fifo.sv
// First-word-fall-through FIFO, DEPTH words; one cycle from push to out_valid on an empty queue.
// in_rdy/out_valid decode only from registered occupancy, so neither side's handshake ripples through.
module vr_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    vr_if.slave                          in_vr,
    vr_if.master                         out_vr,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic w_in_rdy;
    logic w_out_vld;
    logic w_push;
    logic w_pop;

    assign w_in_rdy  = (r_count != FULL_CNT);
    assign w_out_vld = (r_count != '0);
    assign w_push    = in_vr.valid & w_in_rdy;
    assign w_pop     = w_out_vld & out_vr.rdy;

    assign in_vr.rdy    = w_in_rdy;
    assign out_vr.valid = w_out_vld;
    assign out_vr.data  = r_mem[r_rd_ptr];
    assign count        = r_count;

    // Storage carries no reset: contents are invisible while occupancy is zero.
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_mem[r_wr_ptr] <= in_vr.data;
        end
    end

    // DEPTH is a power of two, so natural pointer overflow gives the modulo wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: tb/tb_vr_fifo.sv
// Directed and random stimulus for vr_fifo against a reference queue model.
module tb_vr_fifo;
    localparam int WIDTH = 16;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [$clog2(DEPTH+1)-1:0] count;

    vr_if #(.WIDTH(WIDTH)) in_vr ();
    vr_if #(.WIDTH(WIDTH)) out_vr ();

    vr_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .in_vr  (in_vr),
        .out_vr (out_vr),
        .count  (count)
    );

    always #5 clk = ~clk;

    logic [WIDTH-1:0] q[$];
    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare against the model, predict this edge's transfers, then advance one cycle.
    task automatic step();
        int exp_cnt;
        logic [WIDTH-1:0] exp_dat;
        exp_cnt = q.size();
        chk("count", 32'(count), 32'(exp_cnt));
        chk("in_rdy", 32'(in_vr.rdy), 32'(exp_cnt != DEPTH));
        chk("out_valid", 32'(out_vr.valid), 32'(exp_cnt != 0));
        if (exp_cnt != 0) begin
            chk("out_data", 32'(out_vr.data), 32'(q[0]));
        end
        if (!rst) begin
            if (out_vr.rdy && exp_cnt != 0) begin
                exp_dat = q.pop_front();
            end
            if (in_vr.valid && exp_cnt != DEPTH) begin
                q.push_back(in_vr.data);
            end
        end
        @(posedge clk);
        #1;
        if (rst) begin
            q.delete();
        end
    endtask

    initial begin
        logic acc;
        in_vr.valid = 1'b0;
        in_vr.data  = '0;
        out_vr.rdy  = 1'b0;
        rst         = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_in_rdy", 32'(in_vr.rdy), 32'd1);
        chk("rst_out_valid", 32'(out_vr.valid), 32'd0);

        // Fill to full with the consumer stalled; a fifth word must be refused.
        for (int i = 1; i <= 4; i++) begin
            in_vr.valid = 1'b1;
            in_vr.data  = 16'(i);
            step();
        end
        chk("full_count", 32'(count), 32'd4);
        chk("full_in_rdy", 32'(in_vr.rdy), 32'd0);
        chk("full_head", 32'(out_vr.data), 32'h0001);
        in_vr.data = 16'h0005;
        step();
        step();
        chk("full_hold_count", 32'(count), 32'd4);

        // Drain four words in order.
        in_vr.valid = 1'b0;
        out_vr.rdy  = 1'b1;
        for (int i = 0; i < 4; i++) step();
        chk("drain_out_valid", 32'(out_vr.valid), 32'd0);
        chk("drain_count", 32'(count), 32'd0);

        // Steady state at count=2 with simultaneous push/pop, pointers wrap.
        out_vr.rdy  = 1'b0;
        in_vr.valid = 1'b1;
        in_vr.data  = 16'h0010;
        step();
        in_vr.data  = 16'h0011;
        step();
        out_vr.rdy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_vr.data = 16'(16'h0012 + i);
            step();
        end
        chk("stream_count", 32'(count), 32'd2);
        in_vr.valid = 1'b0;
        step();
        step();

        // Full with push and pop offered together: only the pop happens.
        out_vr.rdy = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            in_vr.valid = 1'b1;
            in_vr.data  = 16'(i);
            step();
        end
        in_vr.data = 16'h0005;
        out_vr.rdy = 1'b1;
        step();
        out_vr.rdy = 1'b0;
        chk("fullpp_count", 32'(count), 32'd3);
        chk("fullpp_in_rdy", 32'(in_vr.rdy), 32'd1);
        step();
        in_vr.valid = 1'b0;
        chk("fullpp_accept", 32'(count), 32'd4);
        out_vr.rdy = 1'b1;
        for (int i = 0; i < 4; i++) step();
        chk("fullpp_drain", 32'(count), 32'd0);

        // Reset mid-stream flushes the queue and wins over push/pop.
        out_vr.rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_vr.valid = 1'b1;
            in_vr.data  = 16'(16'h0020 + i);
            step();
        end
        rst         = 1'b1;
        in_vr.data  = 16'h0099;
        out_vr.rdy  = 1'b1;
        step();
        rst         = 1'b0;
        in_vr.valid = 1'b0;
        out_vr.rdy  = 1'b0;
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_out_valid", 32'(out_vr.valid), 32'd0);
        chk("flush_in_rdy", 32'(in_vr.rdy), 32'd1);
        in_vr.valid = 1'b1;
        in_vr.data  = 16'h00AA;
        step();
        in_vr.valid = 1'b0;
        chk("flush_first", 32'(out_vr.data), 32'h00AA);
        out_vr.rdy = 1'b1;
        step();

        // Random traffic; the producer holds an offered word until it is taken.
        in_vr.valid = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            if (!in_vr.valid || acc) begin
                in_vr.valid = 1'($urandom_range(0, 1));
                in_vr.data  = 16'($urandom);
            end
            out_vr.rdy = 1'($urandom_range(0, 1));
            acc = in_vr.valid && (q.size() != DEPTH);
            step();
        end
        in_vr.valid = 1'b0;
        out_vr.rdy  = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) step();
        chk("final_count", 32'(count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
